blk_prefetch: RTL and testbench

Free-block prefetch buffer between the `mem_manager` occupy port and the packet write path. It keeps up to DEPTH free block addresses ready, so a writer receives a block address with zero request latency instead of waiting out the multi-cycle `ocp_req` → `ocp_vld` exchange. It also owns the single `rls_*` port into `mem_manager`. That port merges writer block releases with a flush path that hands unused prefetched blocks back.

---
 rtl/blk_prefetch_if.sv | 70 +++++++
 rtl/blk_prefetch.sv | 137 +++++++++++++
 tb/tb_blk_prefetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/blk_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : blk_prefetch_if
// Description : Bus bundle between blk_prefetch and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface blk_prefetch_if #(
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH);

    logic              ocp_req;
    logic              ocp_rsp;
    logic [AWIDTH-1:0] ocp_block_addr;
    logic              ocp_vld;
    logic              mm_full;
    logic              rls_vld;
    logic [AWIDTH-1:0] rls_block_addr;
    logic              blk_vld;
    logic [AWIDTH-1:0] blk_addr;
    logic              blk_rdy;
    logic              wr_rls_vld;
    logic [AWIDTH-1:0] wr_rls_addr;
    logic              flush;
    logic              flush_done;
    logic [CW:0]       buf_cnt;
    logic              ovf_err;

    // Prefetch-buffer side
    modport slave (
        output ocp_req,
        input  ocp_rsp,
        input  ocp_block_addr,
        input  ocp_vld,
        input  mm_full,
        output rls_vld,
        output rls_block_addr,
        output blk_vld,
        output blk_addr,
        input  blk_rdy,
        input  wr_rls_vld,
        input  wr_rls_addr,
        input  flush,
        output flush_done,
        output buf_cnt,
        output ovf_err
    );

    // Environment side (mem_manager, writer, control)
    modport master (
        input  ocp_req,
        output ocp_rsp,
        output ocp_block_addr,
        output ocp_vld,
        output mm_full,
        input  rls_vld,
        input  rls_block_addr,
        input  blk_vld,
        input  blk_addr,
        output blk_rdy,
        output wr_rls_vld,
        output wr_rls_addr,
        output flush,
        input  flush_done,
        input  buf_cnt,
        input  ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/blk_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : blk_prefetch
// Description : Free-block prefetch FIFO in front of mem_manager, with a
//               merged writer-release / flush-drain release port.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_prefetch #(
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    blk_prefetch_if.slave bus
);
    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0]   c_FULL    = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] c_PTR_ONE = CW'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW:0]       cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              ocp_req_q, ocp_req_d;
    logic              rls_vld_q, rls_vld_d;
    logic [AWIDTH-1:0] rls_addr_q, rls_addr_d;
    logic              flush_done_q, flush_done_d;
    logic              ovf_q, ovf_d;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop_run;
    logic              w_pop_drain;
    logic              w_pop;
    logic              w_flush_exit;
    logic [AWIDTH-1:0] w_head;
    logic              w_unused;

    // ocp_vld alone marks a valid allocation; the response strobe is not needed
    assign w_unused = bus.ocp_rsp;

    assign w_empty     = (cnt_q == '0);
    assign w_full      = (cnt_q == c_FULL);
    assign w_head      = mem_q[rd_ptr_q];
    assign w_push      = bus.ocp_vld && !w_full;
    assign w_pop_run   = (state_q == ST_RUN) && !w_empty && bus.blk_rdy;
    assign w_pop_drain = (state_q == ST_FLUSH) && !w_empty && !bus.wr_rls_vld;
    assign w_pop       = w_pop_run || w_pop_drain;
    assign w_flush_exit = (state_q == ST_FLUSH) && w_empty && !inflight_q &&
                          !ocp_req_q && !w_pop;

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q + (CW+1)'(w_push) - (CW+1)'(w_pop);
        inflight_d   = inflight_q;
        ocp_req_d    = ocp_req_q;
        rls_vld_d    = 1'b0;
        rls_addr_d   = '0;
        flush_done_d = w_flush_exit;
        ovf_d        = ovf_q || (bus.ocp_vld && w_full);

        case (state_q)
            ST_RUN:   if (bus.flush) state_d = ST_FLUSH;
            ST_FLUSH: if (w_flush_exit) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_ONE;

        if (bus.ocp_vld)
            inflight_d = 1'b0;
        else if (ocp_req_q && !bus.mm_full && !inflight_q)
            inflight_d = 1'b1;

        // The request is frozen while mem_manager owns it; re-evaluate at the
        // completing ocp_vld edge so a full FIFO never triggers one more grant.
        if (!inflight_q || bus.ocp_vld)
            ocp_req_d = (state_q == ST_RUN) && !bus.mm_full && (cnt_d < c_FULL);

        if (bus.wr_rls_vld) begin
            rls_vld_d  = 1'b1;
            rls_addr_d = bus.wr_rls_addr;
        end else if (w_pop_drain) begin
            rls_vld_d  = 1'b1;
            rls_addr_d = w_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            ocp_req_q    <= 1'b0;
            rls_vld_q    <= 1'b0;
            rls_addr_q   <= '0;
            flush_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            ocp_req_q    <= ocp_req_d;
            rls_vld_q    <= rls_vld_d;
            rls_addr_q   <= rls_addr_d;
            flush_done_q <= flush_done_d;
            ovf_q        <= ovf_d;
            if (w_push) mem_q[wr_ptr_q] <= bus.ocp_block_addr;
        end
    end

    assign bus.ocp_req        = ocp_req_q;
    assign bus.rls_vld        = rls_vld_q;
    assign bus.rls_block_addr = rls_addr_q;
    assign bus.blk_vld        = (state_q == ST_RUN) && !w_empty;
    assign bus.blk_addr       = w_head;
    assign bus.flush_done     = flush_done_q;
    assign bus.buf_cnt        = cnt_q;
    assign bus.ovf_err        = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_blk_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_blk_prefetch
// Description : Directed self-checking bench for blk_prefetch (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_prefetch;
    localparam int AWIDTH = 10;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    blk_prefetch_if #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) bus ();

    blk_prefetch #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Stub grant: one cycle for the DUT to latch the request, then ocp_vld.
    task automatic alloc(input logic [AWIDTH-1:0] addr, input logic pop);
        nxt();
        bus.ocp_vld        = 1'b1;
        bus.ocp_block_addr = addr;
        bus.blk_rdy        = pop;
        nxt();
        bus.ocp_vld        = 1'b0;
        bus.ocp_block_addr = '0;
        bus.blk_rdy        = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.ocp_rsp        = 1'b0;
        bus.ocp_block_addr = '0;
        bus.ocp_vld        = 1'b0;
        bus.mm_full        = 1'b0;
        bus.blk_rdy        = 1'b0;
        bus.wr_rls_vld     = 1'b0;
        bus.wr_rls_addr    = '0;
        bus.flush          = 1'b0;

        repeat (2) nxt();
        chk("rst_ocp_req",    32'(bus.ocp_req), 32'd0);
        chk("rst_rls_vld",    32'(bus.rls_vld), 32'd0);
        chk("rst_rls_addr",   32'(bus.rls_block_addr), 32'd0);
        chk("rst_blk_vld",    32'(bus.blk_vld), 32'd0);
        chk("rst_blk_addr",   32'(bus.blk_addr), 32'd0);
        chk("rst_buf_cnt",    32'(bus.buf_cnt), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("rst_ovf",        32'(bus.ovf_err), 32'd0);

        rst_n = 1'b1;
        nxt();
        chk("first_req", 32'(bus.ocp_req), 32'd1);

        // Fill after reset
        alloc(10'h05, 1'b0);
        chk("fill1_cnt",  32'(bus.buf_cnt), 32'd1);
        chk("fill1_vld",  32'(bus.blk_vld), 32'd1);
        chk("fill1_addr", 32'(bus.blk_addr), 32'h05);
        alloc(10'h06, 1'b0);
        alloc(10'h07, 1'b0);
        chk("fill3_req",  32'(bus.ocp_req), 32'd1);
        alloc(10'h08, 1'b0);
        chk("fill4_cnt",  32'(bus.buf_cnt), 32'd4);
        chk("fill4_req",  32'(bus.ocp_req), 32'd0);
        chk("fill4_addr", 32'(bus.blk_addr), 32'h05);
        chk("fill4_vld",  32'(bus.blk_vld), 32'd1);
        nxt();
        chk("full_req_hold", 32'(bus.ocp_req), 32'd0);

        // Single pop refills the request
        bus.blk_rdy = 1'b1;
        nxt();
        bus.blk_rdy = 1'b0;
        chk("pop_cnt",  32'(bus.buf_cnt), 32'd3);
        chk("pop_addr", 32'(bus.blk_addr), 32'h06);
        chk("pop_req",  32'(bus.ocp_req), 32'd1);

        // Simultaneous push and pop, wrapping both pointers
        alloc(10'h09, 1'b1);
        chk("pp1_cnt",  32'(bus.buf_cnt), 32'd3);
        chk("pp1_addr", 32'(bus.blk_addr), 32'h07);
        alloc(10'h0A, 1'b1);
        chk("pp2_addr", 32'(bus.blk_addr), 32'h08);
        alloc(10'h0B, 1'b1);
        chk("pp3_addr", 32'(bus.blk_addr), 32'h09);
        alloc(10'h0C, 1'b1);
        chk("pp4_cnt",  32'(bus.buf_cnt), 32'd3);
        chk("pp4_addr", 32'(bus.blk_addr), 32'h0A);
        chk("pp4_req",  32'(bus.ocp_req), 32'd1);

        // Pop that also lets the request be accepted: inflight=1, buf_cnt=2
        bus.blk_rdy = 1'b1;
        nxt();
        bus.blk_rdy = 1'b0;
        chk("pre_rst_cnt",  32'(bus.buf_cnt), 32'd2);
        chk("pre_rst_addr", 32'(bus.blk_addr), 32'h0B);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  32'(bus.ocp_req), 32'd0);
        chk("arst_vld",  32'(bus.blk_vld), 32'd0);
        chk("arst_addr", 32'(bus.blk_addr), 32'd0);
        chk("arst_cnt",  32'(bus.buf_cnt), 32'd0);
        nxt();
        chk("arst_hold_req", 32'(bus.ocp_req), 32'd0);
        rst_n = 1'b1;
        nxt();
        chk("rst_refill_req", 32'(bus.ocp_req), 32'd1);

        // mm_full blocks the request while empty and idle
        bus.mm_full = 1'b1;
        nxt();
        chk("mmfull_req", 32'(bus.ocp_req), 32'd0);
        chk("mmfull_vld", 32'(bus.blk_vld), 32'd0);
        bus.mm_full = 1'b0;
        nxt();
        chk("mmfull_fall_req", 32'(bus.ocp_req), 32'd1);

        // Flush with three entries and a writer release in the drain window
        alloc(10'h11, 1'b0);
        alloc(10'h12, 1'b0);
        alloc(10'h13, 1'b0);
        chk("fl_pre_cnt", 32'(bus.buf_cnt), 32'd3);
        bus.flush   = 1'b1;
        bus.mm_full = 1'b1;
        nxt();
        bus.flush   = 1'b0;
        bus.mm_full = 1'b0;
        chk("fl0_vld", 32'(bus.blk_vld), 32'd0);
        chk("fl0_req", 32'(bus.ocp_req), 32'd0);
        chk("fl0_rls", 32'(bus.rls_vld), 32'd0);
        nxt();
        chk("fl1_rls",  32'(bus.rls_vld), 32'd1);
        chk("fl1_addr", 32'(bus.rls_block_addr), 32'h11);
        bus.wr_rls_vld  = 1'b1;
        bus.wr_rls_addr = 10'h3F;
        nxt();
        bus.wr_rls_vld  = 1'b0;
        bus.wr_rls_addr = '0;
        chk("fl2_rls",  32'(bus.rls_vld), 32'd1);
        chk("fl2_addr", 32'(bus.rls_block_addr), 32'h3F);
        chk("fl2_cnt",  32'(bus.buf_cnt), 32'd2);
        chk("fl2_vld",  32'(bus.blk_vld), 32'd0);
        nxt();
        chk("fl3_addr", 32'(bus.rls_block_addr), 32'h12);
        chk("fl3_vld",  32'(bus.blk_vld), 32'd0);
        nxt();
        chk("fl4_rls",  32'(bus.rls_vld), 32'd1);
        chk("fl4_addr", 32'(bus.rls_block_addr), 32'h13);
        chk("fl4_cnt",  32'(bus.buf_cnt), 32'd0);
        chk("fl4_done", 32'(bus.flush_done), 32'd0);
        nxt();
        chk("fl5_done",     32'(bus.flush_done), 32'd1);
        chk("fl5_rls",      32'(bus.rls_vld), 32'd0);
        chk("fl5_rls_addr", 32'(bus.rls_block_addr), 32'd0);
        chk("fl5_req",      32'(bus.ocp_req), 32'd0);
        nxt();
        chk("fl6_done", 32'(bus.flush_done), 32'd0);
        chk("fl6_req",  32'(bus.ocp_req), 32'd1);

        // Flush one cycle after the request is accepted
        nxt();
        bus.flush = 1'b1;
        nxt();
        bus.flush = 1'b0;
        chk("fi_req_held", 32'(bus.ocp_req), 32'd1);
        chk("fi_vld",      32'(bus.blk_vld), 32'd0);
        bus.ocp_vld        = 1'b1;
        bus.ocp_block_addr = 10'h20;
        nxt();
        bus.ocp_vld        = 1'b0;
        bus.ocp_block_addr = '0;
        chk("fi_push_cnt", 32'(bus.buf_cnt), 32'd1);
        chk("fi_req_low",  32'(bus.ocp_req), 32'd0);
        chk("fi_vld2",     32'(bus.blk_vld), 32'd0);
        nxt();
        chk("fi_rls",      32'(bus.rls_vld), 32'd1);
        chk("fi_rls_addr", 32'(bus.rls_block_addr), 32'h20);
        chk("fi_cnt",      32'(bus.buf_cnt), 32'd0);
        nxt();
        chk("fi_done", 32'(bus.flush_done), 32'd1);
        nxt();
        chk("fi_done_clr", 32'(bus.flush_done), 32'd0);
        chk("fi_refill",   32'(bus.ocp_req), 32'd1);
        chk("final_ovf",   32'(bus.ovf_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
